// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU Signal codes, ALUOp values and R-type funct codes.
package id_ex_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_sig_e;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BEQ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ORI   = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/id_ex_stage_alu_ctl.sv
// ALU control decoder: maps the registered ALUOp/funct pair onto the 3-bit ALU Signal.
module id_ex_stage_alu_ctl
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] signal_o,
  output logic       illegal_o
);

  always_comb begin
    signal_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_MEM: signal_o = ALU_ADD;
      ALUOP_BEQ: signal_o = ALU_SUB;
      ALUOP_ORI: signal_o = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: signal_o = ALU_ADD;
          FUNCT_SUB: signal_o = ALU_SUB;
          FUNCT_AND: signal_o = ALU_AND;
          FUNCT_OR:  signal_o = ALU_OR;
          FUNCT_SLT: signal_o = ALU_SLT;
          // Unsupported funct still drives a harmless ADD
          default: begin
            signal_o  = ALU_ADD;
            illegal_o = 1'b1;
          end
        endcase
      end
      default: signal_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX/MEM + MEM/WB operand forwarding,
// load-use bubble insertion, external stall and branch flush.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_aluop,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic              id_branch,
  input  logic              exmem_regwrite,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              load_use_hazard,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_signal,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_dest,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_branch,
  output logic              ex_illegal
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [5:0]        funct;
    logic [1:0]        aluop;
    logic              alusrc;
    logic              regdst;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic              memtoreg;
    logic              branch;
  } idex_t;

  idex_t ex_q, ex_d, id_s;
  logic [DATA_W-1:0] fwd_rs_s, fwd_rt_s;
  logic              illegal_s;

  assign id_s = '{valid: id_valid, rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
                  rs: id_rs, rt: id_rt, rd: id_rd, funct: id_funct, aluop: id_aluop,
                  alusrc: id_alusrc, regdst: id_regdst, memread: id_memread,
                  memwrite: id_memwrite, regwrite: id_regwrite, memtoreg: id_memtoreg,
                  branch: id_branch};

  // A stalled or flushed cycle never also requests a load-use hold
  assign load_use_hazard = id_valid & ex_q.valid & ex_q.memread & (ex_q.rt != '0)
                         & ((ex_q.rt == id_rs) | (ex_q.rt == id_rt)) & ~stall & ~flush;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use_hazard) begin
      ex_d = '0;
    end else begin
      ex_d = id_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_W-1:0]  src,
    input logic [DATA_W-1:0] reg_val,
    input logic              em_we,
    input logic [REG_W-1:0]  em_rd,
    input logic [DATA_W-1:0] em_val,
    input logic              mw_we,
    input logic [REG_W-1:0]  mw_rd,
    input logic [DATA_W-1:0] mw_val
  );
    if (em_we && (em_rd != '0) && (em_rd == src)) begin
      return em_val;
    end else if (mw_we && (mw_rd != '0) && (mw_rd == src)) begin
      return mw_val;
    end else begin
      return reg_val;
    end
  endfunction

  assign fwd_rs_s = fwd_sel(ex_q.rs, ex_q.rs_data, exmem_regwrite, exmem_rd, exmem_result,
                            memwb_regwrite, memwb_rd, memwb_data);
  assign fwd_rt_s = fwd_sel(ex_q.rt, ex_q.rt_data, exmem_regwrite, exmem_rd, exmem_result,
                            memwb_regwrite, memwb_rd, memwb_data);

  id_ex_stage_alu_ctl u_alu_ctl (
    .aluop_i   (ex_q.aluop),
    .funct_i   (ex_q.funct),
    .signal_o  (alu_signal),
    .illegal_o (illegal_s)
  );

  assign alu_a         = fwd_rs_s;
  assign alu_b         = ex_q.alusrc ? ex_q.imm : fwd_rt_s;
  assign ex_store_data = fwd_rt_s;
  assign ex_dest       = ex_q.regdst ? ex_q.rd : ex_q.rt;
  assign ex_valid      = ex_q.valid;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memtoreg   = ex_q.memtoreg;
  assign ex_branch     = ex_q.branch;
  assign ex_illegal    = ex_q.valid & illegal_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vectors with literal expectations plus a
// behavioural reference checked against every output on every falling clock edge.
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_aluop;
  logic        id_alusrc, id_regdst, id_memread, id_memwrite, id_regwrite, id_memtoreg, id_branch;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_data;
  logic        load_use_hazard, ex_valid, ex_memread, ex_memwrite, ex_regwrite;
  logic        ex_memtoreg, ex_branch, ex_illegal;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_signal;
  logic [4:0]  ex_dest;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_branch(id_branch), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .load_use_hazard(load_use_hazard), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the instruction sitting in EX is
  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        alusrc, regdst, memread, memwrite, regwrite, memtoreg, branch;
  } stage_t;
  stage_t m = '0;

  function automatic logic model_hazard();
    return id_valid && m.valid && m.memread && (m.rt != 5'd0) &&
           ((m.rt == id_rs) || (m.rt == id_rt)) && !stall && !flush;
  endfunction

  function automatic logic [2:0] model_sig(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 3'b010;
    if (op == 2'b01) return 3'b110;
    if (op == 2'b11) return 3'b001;
    if (f == 6'b100010) return 3'b110;
    if (f == 6'b100100) return 3'b000;
    if (f == 6'b100101) return 3'b001;
    if (f == 6'b101010) return 3'b111;
    return 3'b010;
  endfunction

  function automatic logic model_illegal(input logic [1:0] op, input logic [5:0] f);
    return (op == 2'b10) &&
           !(f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] src, input logic [31:0] val);
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == src) return exmem_result;
    if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == src) return memwb_data;
    return val;
  endfunction

  always @(posedge clk) begin
    if (rst || flush || (!stall && model_hazard())) begin
      m <= '0;
    end else if (!stall) begin
      m <= '{id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_funct,
             id_aluop, id_alusrc, id_regdst, id_memread, id_memwrite, id_regwrite,
             id_memtoreg, id_branch};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_hazard", 32'(load_use_hazard), 32'(model_hazard()));
      check("m_valid", 32'(ex_valid), 32'(m.valid));
      check("m_alu_a", alu_a, model_fwd(m.rs, m.rs_data));
      check("m_alu_b", alu_b, m.alusrc ? m.imm : model_fwd(m.rt, m.rt_data));
      check("m_store", ex_store_data, model_fwd(m.rt, m.rt_data));
      check("m_signal", 32'(alu_signal), 32'(model_sig(m.aluop, m.funct)));
      check("m_dest", 32'(ex_dest), 32'(m.regdst ? m.rd : m.rt));
      check("m_ctrl", {27'd0, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch},
            {27'd0, m.memread, m.memwrite, m.regwrite, m.memtoreg, m.branch});
      check("m_illegal", 32'(ex_illegal), 32'(m.valid && model_illegal(m.aluop, m.funct)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 1'b0; id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_funct = 6'd0; id_aluop = 2'b00;
    id_alusrc = 1'b0; id_regdst = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
    id_regwrite = 1'b0; id_memtoreg = 1'b0; id_branch = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;
  endtask

  initial begin
    logic [5:0] functs [6];
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000011};
    clear_id();
    stall = 1'b0; flush = 1'b0; rst = 1'b1;
    id_valid = 1'b1; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rs = 5'd7; id_rt = 5'd9; id_regwrite = 1'b1; id_aluop = 2'b10; id_funct = 6'b101010;
    step();
    chk_en = 1'b1;
    step();
    #1;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_regwrite", 32'(ex_regwrite), 32'd0);
    check("rst_signal", 32'(alu_signal), 32'(3'b010));
    check("rst_alu_a", alu_a, 32'd0);
    rst = 1'b0;

    // R-type SLT, then unsupported funct
    clear_id();
    id_valid = 1'b1; id_aluop = 2'b10; id_funct = 6'b101010; id_rs = 5'd1; id_rt = 5'd2;
    id_rd = 5'd3; id_rs_data = 32'd5; id_rt_data = 32'd9; id_regdst = 1'b1; id_regwrite = 1'b1;
    step(); #1;
    check("slt_signal", 32'(alu_signal), 32'(3'b111));
    check("slt_alu_a", alu_a, 32'd5);
    check("slt_alu_b", alu_b, 32'd9);
    id_funct = 6'b111111;
    step(); #1;
    check("bad_illegal", 32'(ex_illegal), 32'd1);
    check("bad_signal", 32'(alu_signal), 32'(3'b010));

    // Forwarding priority on operand A
    clear_id();
    id_valid = 1'b1; id_rs = 5'd3; id_rs_data = 32'h11;
    step();
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_data = 32'hBB;
    #1 check("fwd_exmem", alu_a, 32'hAA);
    exmem_regwrite = 1'b0;
    #1 check("fwd_memwb", alu_a, 32'hBB);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1 check("fwd_r0", alu_a, 32'h11);

    // Load-use: lw rt=4 followed by add using $4
    clear_id();
    id_valid = 1'b1; id_memread = 1'b1; id_regwrite = 1'b1; id_memtoreg = 1'b1;
    id_alusrc = 1'b1; id_rs = 5'd1; id_rt = 5'd4; id_imm = 32'd8;
    step();
    id_memread = 1'b0; id_memtoreg = 1'b0; id_alusrc = 1'b0; id_imm = 32'd0;
    id_rs = 5'd4; id_rt = 5'd5; id_rd = 5'd6; id_aluop = 2'b10; id_funct = 6'b100000;
    id_regdst = 1'b1; id_rs_data = 32'd100; id_rt_data = 32'd200;
    #1 check("lu_hazard", 32'(load_use_hazard), 32'd1);
    step(); #1;
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_regwrite", 32'(ex_regwrite), 32'd0);
    check("lu_released", 32'(load_use_hazard), 32'd0);
    step(); #1;
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_dest", 32'(ex_dest), 32'd6);
    check("add_alu_a", alu_a, 32'd100);

    // Stall holds, stall+flush bubbles
    stall = 1'b1; id_rd = 5'd9; id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      check("stall_dest", 32'(ex_dest), 32'd6);
      check("stall_valid", 32'(ex_valid), 32'd1);
    end
    flush = 1'b1;
    step(); #1;
    check("flush_valid", 32'(ex_valid), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Hazard suppressed under stall/flush
    clear_id();
    id_valid = 1'b1; id_memread = 1'b1; id_rt = 5'd4;
    step();
    id_memread = 1'b0; id_rt = 5'd0; id_rs = 5'd4; stall = 1'b1;
    #1 check("hz_stall", 32'(load_use_hazard), 32'd0);
    stall = 1'b0;
    #1 check("hz_free", 32'(load_use_hazard), 32'd1);
    flush = 1'b1;
    #1 check("hz_flush", 32'(load_use_hazard), 32'd0);
    flush = 1'b0;
    step();

    // ALUSrc immediate path
    clear_id();
    id_valid = 1'b1; id_alusrc = 1'b1; id_imm = 32'hFFFFFFFC; id_rt = 5'd2; id_rt_data = 32'd7;
    step(); #1;
    check("imm_alu_b", alu_b, 32'hFFFFFFFC);
    check("imm_store", ex_store_data, 32'd7);
    check("imm_signal", 32'(alu_signal), 32'(3'b010));

    // Mixed traffic, checked only by the reference model
    for (int i = 0; i < 60; i++) begin
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom_range(0, 5)); id_rt = 5'($urandom_range(0, 5));
      id_rd = 5'($urandom_range(0, 31));
      id_aluop = 2'($urandom_range(0, 3)); id_funct = functs[$urandom_range(0, 5)];
      {id_alusrc, id_regdst, id_memread, id_memwrite, id_regwrite, id_memtoreg, id_branch}
        = 7'($urandom);
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 5));
      exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 5));
      memwb_data = $urandom;
      stall = 1'($urandom_range(0, 7) == 0); flush = 1'($urandom_range(0, 9) == 0);
      step();
    end
    stall = 1'b0; flush = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit EX ALU.
- Registers decoded-instruction fields on each clock and decodes ALUOp/funct into the 3-bit ALU Signal code.
- Applies EX/MEM and MEM/WB forwarding to produce the ALU operands dataA/dataB.
- Detects load-use hazards and inserts bubbles; supports external stall and branch flush.

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register-address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
stall  in  1  hold ID/EX contents (e.g. memory wait)
flush  in  1  replace next ID/EX contents with bubble (taken branch)
id_valid  in  1  ID holds a real instruction
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_W  register addresses
id_funct  in  6  instruction funct field
id_aluop  in  2  main-decoder ALUOp
id_alusrc, id_regdst, id_memread, id_memwrite, id_regwrite, id_memtoreg, id_branch  in  1 each  main-decoder controls
exmem_regwrite  in  1  EX/MEM write enable
exmem_rd  in  REG_W  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_regwrite  in  1  MEM/WB write enable
memwb_rd  in  REG_W  MEM/WB destination
memwb_data  in  DATA_W  MEM/WB writeback data
load_use_hazard  out  1  combinational; IF/ID and PC must hold this cycle
ex_valid  out  1  registered valid
alu_a, alu_b  out  DATA_W  forwarded ALU operands (to dataA/dataB)
alu_signal  out  3  ALU control (to Signal)
ex_store_data  out  DATA_W  forwarded rt value for sw
ex_dest  out  REG_W  destination: rd if regdst else rt
ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch  out  1 each  registered controls
ex_illegal  out  1  valid R-type with unsupported funct

Behaviour:
- Reset: all registered fields 0. ex_valid=0, all ex_* controls 0, alu_signal=010, alu_a=alu_b=0.
- Per clock, priority order:
  - rst: clear all.
  - flush: load bubble.
  - stall: hold all registers.
  - load_use_hazard: load bubble.
  - Otherwise: capture all id_* fields; valid<=id_valid.
- Bubble: valid and memread/memwrite/regwrite/branch/memtoreg = 0; all data and address fields = 0.
- flush with stall in the same cycle: flush wins.
- load_use_hazard = ex_valid & ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)), gated by id_valid.
- load_use_hazard forced 0 while stall or flush is asserted.
- ALU control, combinational from registered aluop/funct:
  - aluop 00 -> 010 (ADD, lw/sw).
  - aluop 01 -> 110 (SUB, beq).
  - aluop 11 -> 001 (OR, ori).
  - aluop 10, by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - aluop 10 with any other funct -> 010, and ex_illegal = ex_valid.
- Forwarding, combinational, per operand (rs -> A, rt -> B/store):
  - If exmem_regwrite & exmem_rd != 0 & exmem_rd == src: use exmem_result.
  - Else if memwb_regwrite & memwb_rd != 0 & memwb_rd == src: use memwb_data.
  - Else: use registered data.
  - EX/MEM has priority over MEM/WB.
- alu_b = ex_alusrc ? ex_imm : forwarded rt. ex_store_data = forwarded rt always.
- Latency: one cycle, ID inputs to ex_* outputs; forwarding and decode add zero cycles.
- Register $0 is never forwarded.

Decomposition:
- Shared package holds:
  - ALU Signal constants AND=000, OR=001, ADD=010, SUB=110, SLT=111.
  - ALUOp encodings 00/01/10/11.
  - funct constants.
- Sub-module alu_ctl: combinational ALUOp/funct -> Signal plus illegal flag.
- Forwarding muxes and hazard logic stay inline.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1 and random inputs -> ex_valid=0, ex_regwrite=0, alu_signal=010, alu_a=0.
- R-type decode: aluop=10, funct=101010, rs_data=5, rt_data=9 -> next cycle alu_signal=111, alu_a=5, alu_b=9. Repeat with funct=111111 -> ex_illegal=1, alu_signal=010.
- Forwarding priority: ex_rs=3, exmem_rd=3 with result 0xAA, memwb_rd=3 with data 0xBB -> alu_a=0xAA. Drop exmem_regwrite -> alu_a=0xBB. Set rd=0 on both -> alu_a = registered rs data.
- Load-use: lw with ex_rt=4 in EX, id_rs=4 -> load_use_hazard=1; next cycle ex_valid=0, ex_regwrite=0; ID held one cycle, then add captured normally.
- Stall/flush: stall=1 for 3 cycles -> ex_* outputs unchanged. stall=1 & flush=1 together -> bubble loaded (ex_valid=0).
- ALUSrc: alusrc=1, aluop=00, imm=0xFFFFFFFC, rt_data=7 -> alu_b=0xFFFFFFFC, ex_store_data=7, alu_signal=010.
